// File: rtl/pmp_checker_seq_if.sv
//------------------------------------------------------------------------------
// pmp_checker_seq_if
// Request/response handshake bundle between an address source and the
// sequential PMP checker.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface pmp_checker_seq_if #(
  parameter int XW = 64
);
  logic          i_req_valid;
  logic          o_req_ready;
  logic [XW-1:0] i_addr;
  logic [1:0]    i_access_type;
  logic [1:0]    i_privilege;
  logic          i_flush;
  logic          o_resp_valid;
  logic          i_resp_ready;
  logic          o_fault;
  logic [3:0]    o_exception_code;
  logic [5:0]    o_match_idx;
  logic          o_busy;

  modport slave (
    input  i_req_valid, i_addr, i_access_type, i_privilege, i_flush, i_resp_ready,
    output o_req_ready, o_resp_valid, o_fault, o_exception_code, o_match_idx, o_busy
  );

  modport master (
    output i_req_valid, i_addr, i_access_type, i_privilege, i_flush, i_resp_ready,
    input  o_req_ready, o_resp_valid, o_fault, o_exception_code, o_match_idx, o_busy
  );
endinterface

`default_nettype wire

// File: rtl/pmp_checker_seq.sv
//------------------------------------------------------------------------------
// pmp_checker_seq
// Multi-cycle PMP checker scanning ENTRIES_PER_CYCLE entries per cycle;
// lowest matching entry decides. Optional macro: PMP_LOCK_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

`ifndef XLEN_64b
`define XLEN_64b 2'b10
`endif
`ifndef MACHINE
`define MACHINE 2'b11
`endif
`ifndef NO_E
`define NO_E 4'd0
`endif
`ifndef E_ILLEGAL_INSTR
`define E_ILLEGAL_INSTR 4'd2
`endif
`ifndef E_LOAD_ACCESS_FAULT
`define E_LOAD_ACCESS_FAULT 4'd5
`endif
`ifndef E_STORE_ACCESS_FAULT
`define E_STORE_ACCESS_FAULT 4'd7
`endif

module pmp_checker_seq #(
  parameter logic [1:0] XLEN              = `XLEN_64b,
  parameter int         NUM_ENTRIES       = 16,
  parameter int         ENTRIES_PER_CYCLE = 4,
  localparam int        XW                = 1 << (int'(XLEN) + 4)
) (
  input  wire logic                      i_clk,
  input  wire logic                      i_rst,
  pmp_checker_seq_if.slave               bus,
  input  wire logic [NUM_ENTRIES*XW-1:0] i_concat_pmpaddr,
  input  wire logic [NUM_ENTRIES*8-1:0]  i_concat_pmpcfg
);

  localparam int EPC        = ENTRIES_PER_CYCLE;
  localparam int NUM_CHUNKS = NUM_ENTRIES / EPC;
  localparam int CHUNK_W    = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

  localparam logic [CHUNK_W-1:0] c_LAST_CHUNK = CHUNK_W'(NUM_CHUNKS - 1);
  localparam logic [5:0]         c_NO_MATCH   = 6'd63;
  localparam logic [3:0]         c_NO_E       = `NO_E;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]         r_state;
  logic [CHUNK_W-1:0] r_chunk;
  logic [XW-1:0]      r_addr;
  logic [1:0]         r_type;
  logic [1:0]         r_priv;
  logic               r_fault;
  logic [3:0]         r_code;
  logic [5:0]         r_idx;

  logic [NUM_ENTRIES-1:0] w_app_hit;
  logic [NUM_ENTRIES-1:0] w_perm_ok;
  logic [NUM_ENTRIES-1:0] w_unused_cfg;
  logic                   w_priv_m;
  logic [3:0]             w_fault_code;

  assign w_priv_m = (r_priv == `MACHINE);

  always_comb begin
    case (r_type)
      2'b00:   w_fault_code = `E_ILLEGAL_INSTR;
      2'b10:   w_fault_code = `E_STORE_ACCESS_FAULT;
      default: w_fault_code = `E_LOAD_ACCESS_FAULT;
    endcase
  end

  for (genvar j = 0; j < NUM_ENTRIES; j++) begin : g_entry
    logic [XW-1:0] w_pa;
    logic [XW-1:0] w_base;
    logic [XW-1:0] w_lo;
    logic [XW-1:0] w_napot_mask;
    logic [7:0]    w_cfg;
    logic          w_tor;
    logic          w_na4;
    logic          w_napot;
    logic          w_match;
    logic          w_applies;

    assign w_pa   = i_concat_pmpaddr[j*XW +: XW];
    assign w_cfg  = i_concat_pmpcfg[j*8 +: 8];
    assign w_base = w_pa << 2;

    if (j == 0) begin : g_lo_zero
      assign w_lo = '0;
    end else begin : g_lo_prev
      assign w_lo = i_concat_pmpaddr[(j-1)*XW +: XW] << 2;
    end

    assign w_tor = (w_lo < w_base) && (r_addr >= w_lo) && (r_addr < w_base);
    assign w_na4 = (r_addr >= w_base) && ((r_addr - w_base) < XW'(4));
    // Trailing ones of pmpaddr plus the first zero give the region mask once shifted.
    assign w_napot_mask = ((w_pa ^ (w_pa + XW'(1))) << 2) | XW'(3);
    assign w_napot = (((r_addr ^ ((w_pa & (w_pa + XW'(1))) << 2)) & ~w_napot_mask) == '0);

    always_comb begin
      case (w_cfg[4:3])
        2'b01:   w_match = w_tor;
        2'b10:   w_match = w_na4;
        2'b11:   w_match = w_napot;
        default: w_match = 1'b0;
      endcase
    end

`ifdef PMP_LOCK_EN
    assign w_applies = (w_cfg[4:3] != 2'b00) && (!w_priv_m || w_cfg[7]);
`else
    assign w_applies = (w_cfg[4:3] != 2'b00);
`endif

    assign w_app_hit[j]    = w_applies && w_match;
    assign w_perm_ok[j]    = (r_type == 2'b00) ? w_cfg[2] :
                             (r_type == 2'b10) ? w_cfg[1] : w_cfg[0];
    assign w_unused_cfg[j] = ^w_cfg[7:5];
  end

  logic [EPC-1:0] w_chunk_hit;
  logic [EPC-1:0] w_chunk_perm;
  logic           w_hit;
  logic           w_hit_perm;
  logic [5:0]     w_hit_off;
  logic [5:0]     w_hit_idx;

  assign w_chunk_hit  = EPC'(w_app_hit >> (r_chunk * EPC));
  assign w_chunk_perm = EPC'(w_perm_ok >> (r_chunk * EPC));

  // Walk downward so the lowest-indexed hit in the chunk is the one that sticks.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_perm = 1'b0;
    w_hit_off  = '0;
    for (int k = EPC - 1; k >= 0; k--) begin
      if (w_chunk_hit[k]) begin
        w_hit      = 1'b1;
        w_hit_perm = w_chunk_perm[k];
        w_hit_off  = 6'(k);
      end
    end
  end

  assign w_hit_idx = 6'(r_chunk * EPC) + w_hit_off;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_chunk <= '0;
      r_addr  <= '0;
      r_type  <= '0;
      r_priv  <= '0;
      r_fault <= 1'b0;
      r_code  <= c_NO_E;
      r_idx   <= c_NO_MATCH;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.i_req_valid) begin
            r_addr  <= bus.i_addr;
            r_type  <= bus.i_access_type;
            r_priv  <= bus.i_privilege;
            r_chunk <= '0;
            r_state <= S_SCAN;
`ifndef PMP_LOCK_EN
            if (bus.i_privilege == `MACHINE) begin
              r_state <= S_RESP;
              r_fault <= 1'b0;
              r_code  <= c_NO_E;
              r_idx   <= c_NO_MATCH;
            end
`endif
          end
        end
        S_SCAN: begin
          if (bus.i_flush) begin
            r_state <= S_IDLE;
          end else if (w_hit) begin
            r_state <= S_RESP;
            r_fault <= !w_hit_perm;
            r_code  <= w_hit_perm ? c_NO_E : w_fault_code;
            r_idx   <= w_hit_idx;
          end else if (r_chunk == c_LAST_CHUNK) begin
            r_state <= S_RESP;
            r_fault <= !w_priv_m;
            r_code  <= w_priv_m ? c_NO_E : w_fault_code;
            r_idx   <= c_NO_MATCH;
          end else begin
            r_chunk <= r_chunk + CHUNK_W'(1);
          end
        end
        S_RESP: begin
          if (bus.i_flush || bus.i_resp_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_req_ready      = (r_state == S_IDLE);
  assign bus.o_resp_valid     = (r_state == S_RESP);
  assign bus.o_busy           = (r_state != S_IDLE);
  assign bus.o_fault          = r_fault;
  assign bus.o_exception_code = r_code;
  assign bus.o_match_idx      = r_idx;

endmodule

`default_nettype wire
